adc_scan_controller: RTL and testbench

ADC_SCAN_CONTROLLER -- requirements
Module: adc_scan_controller

---
 rtl/adc_scan_pkg.sv | 27 ++
 rtl/adc_scan_if.sv | 26 ++
 rtl/adc_sample_bank.sv | 35 +++
 rtl/adc_scan_controller.sv | 145 ++++++++++++++
 tb/tb_adc_scan_controller.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_scan_pkg.sv
// Shared state type, default parameters and sizing helper for the ADC scan controller.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        START,
        WAIT,
        DONE
    } scan_state_t;

    localparam int DEF_DATA_W         = 8;
    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_SETTLE_CYCLES  = 2;
    localparam int DEF_WR_LOW_CYCLES  = 5;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // One phase counter serves every timed state, so it must hold the longest phase minus one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/adc_scan_if.sv
// Parallel ADC bus: start strobe and mux address out, end-of-conversion and result back.
interface adc_scan_if
    import adc_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = 2
);
    logic              wr;
    logic [CH_W-1:0]   ch_sel;
    logic              intrupt;
    logic [DATA_W-1:0] digital_data;

    modport master (
        output wr,
        output ch_sel,
        input  intrupt,
        input  digital_data
    );

    modport slave (
        input  wr,
        input  ch_sel,
        output intrupt,
        output digital_data
    );
endinterface

// File: rtl/adc_sample_bank.sv
// Per-channel sample storage with a registered display read port.
module adc_sample_bank
    import adc_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [CH_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [CH_W-1:0]   disp_ch,
    output logic [DATA_W-1:0] led_display
);

    logic [DATA_W-1:0] slots [NUM_CH];

    // The read samples the slot before a same-edge write lands, so a fresh capture shows one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                slots[i] <= '0;
            end
            led_display <= '0;
        end else begin
            if (we) begin
                slots[waddr] <= wdata;
            end
            led_display <= (32'(disp_ch) < NUM_CH) ? slots[disp_ch] : '0;
        end
    end

endmodule

// File: rtl/adc_scan_controller.sv
// Round-robin ADC scanner: settle mux, pulse wr low, wait for end-of-conversion, store per channel.
// Optional WAIT timeout with sticky error flag when ADC_SCAN_TIMEOUT_EN is defined.
module adc_scan_controller
    import adc_scan_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int WR_LOW_CYCLES  = DEF_WR_LOW_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [CH_W-1:0]   disp_ch,
    input  logic              err_clr,
    adc_scan_if.master        adc,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic [DATA_W-1:0] led_display,
    output logic              timeout_err,
    output logic              busy
);

    localparam int              CNT_W       = cnt_width(SETTLE_CYCLES, WR_LOW_CYCLES, TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOW_LAST = CNT_W'(WR_LOW_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    scan_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic              bank_we;
    logic [CH_W-1:0]   next_ch;

    assign bank_we = (state == WAIT) && !adc.intrupt;
    assign next_ch = (adc.ch_sel == LAST_CH) ? '0 : adc.ch_sel + CH_W'(1);

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign timeout_err    = 1'b0;
`endif

    // wr and busy are set on the transition into a state so they are valid for that state's whole span.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            adc.wr       <= 1'b1;
            adc.ch_sel   <= '0;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
        end else begin
            sample_valid <= 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
            if (err_clr) begin
                timeout_err <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        state  <= START;
                        cnt    <= '0;
                        adc.wr <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                START: begin
                    if (cnt == WR_LOW_LAST) begin
                        state  <= WAIT;
                        cnt    <= '0;
                        adc.wr <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (!adc.intrupt) begin
                        state        <= DONE;
                        cnt          <= '0;
                        sample_data  <= adc.digital_data;
                        sample_ch    <= adc.ch_sel;
                        sample_valid <= 1'b1;
                    end
`ifdef ADC_SCAN_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        timeout_err <= 1'b1;
                        adc.ch_sel  <= next_ch;
                        cnt         <= '0;
                        state       <= enable ? SETTLE : IDLE;
                        busy        <= enable;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                DONE: begin
                    adc.ch_sel <= next_ch;
                    cnt        <= '0;
                    state      <= enable ? SETTLE : IDLE;
                    busy       <= enable;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    adc.wr <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    adc_sample_bank #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .we          (bank_we),
        .waddr       (adc.ch_sel),
        .wdata       (adc.digital_data),
        .disp_ch     (disp_ch),
        .led_display (led_display)
    );

endmodule

// File: tb/tb_adc_scan_controller.sv
// Randomized self-checking bench for adc_scan_controller against a per-channel transaction model.
module tb_adc_scan_controller;

    localparam int DATA_W         = 8;
    localparam int NUM_CH         = 4;
    localparam int CH_W           = 2;
    localparam int SETTLE_CYCLES  = 2;
    localparam int WR_LOW_CYCLES  = 5;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int WAIT_BOUND     = 60;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [CH_W-1:0]   disp_ch;
    logic              err_clr;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              sample_valid;
    logic [DATA_W-1:0] led_display;
    logic              timeout_err;
    logic              busy;

    adc_scan_if #(.DATA_W(DATA_W), .CH_W(CH_W)) adc();

    adc_scan_controller #(
        .DATA_W         (DATA_W),
        .NUM_CH         (NUM_CH),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .WR_LOW_CYCLES  (WR_LOW_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CH_W           (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .disp_ch      (disp_ch),
        .err_clr      (err_clr),
        .adc          (adc),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .led_display  (led_display),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    logic [DATA_W-1:0] bank_model [NUM_CH];
    int              exp_ch;
    bit              stray_valid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitWr(input logic level, output int n);
        n = 0;
        while (adc.wr !== level && n < WAIT_BOUND) begin
            if (sample_valid === 1'b1) stray_valid = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("wr_reach", 32'(adc.wr), 32'(level));
    endtask

    // One full conversion of the model's current channel, with the ADC answering after 'delay' WAIT cycles.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input int delay, input bit early_low,
                                 input bit chk_settle, input bit drop_en);
        int n;
        int low;
        int ch;
        logic [DATA_W-1:0] old_val;
        ch          = exp_ch;
        stray_valid = 1'b0;
        disp_ch     = CH_W'(ch);
        if (early_low) begin
            adc.intrupt      = 1'b0;
            adc.digital_data = data;
        end
        waitWr(1'b0, n);
        if (chk_settle) checkOutput("settle_gap", 32'(n), 32'(SETTLE_CYCLES));
        checkOutput("ch_sel_conv", 32'(adc.ch_sel), 32'(ch));
        low = 0;
        while (adc.wr === 1'b0 && low < WAIT_BOUND) begin
            if (sample_valid === 1'b1) stray_valid = 1'b1;
            if (drop_en && low == 1) enable = 1'b0;
            @(negedge clk);
            low++;
        end
        checkOutput("wr_low_width", 32'(low), 32'(WR_LOW_CYCLES));
        repeat (delay) begin
            if (sample_valid === 1'b1) stray_valid = 1'b1;
            @(negedge clk);
        end
        old_val          = bank_model[ch];
        adc.intrupt      = 1'b0;
        adc.digital_data = data;
        @(negedge clk);
        checkOutput("stray_valid", 32'(stray_valid), 32'(0));
        checkOutput("valid_pulse", 32'(sample_valid), 32'(1));
        checkOutput("sample_ch", 32'(sample_ch), 32'(ch));
        checkOutput("sample_data", 32'(sample_data), 32'(data));
        checkOutput("led_same_cycle", 32'(led_display), 32'(old_val));
        adc.intrupt      = 1'b1;
        adc.digital_data = DATA_W'($urandom);
        bank_model[ch]   = data;
        exp_ch           = (ch + 1) % NUM_CH;
        disp_ch          = CH_W'($urandom_range(0, NUM_CH - 1));
        @(negedge clk);
        checkOutput("valid_single", 32'(sample_valid), 32'(0));
        checkOutput("ch_advance", 32'(adc.ch_sel), 32'(exp_ch));
        checkOutput("led_display", 32'(led_display), 32'(bank_model[disp_ch]));
        checkOutput("busy_after", 32'(busy), 32'(enable));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        bit wr_high_all;

        rst              = 1'b1;
        enable           = 1'b0;
        disp_ch          = '0;
        err_clr          = 1'b0;
        adc.intrupt      = 1'b1;
        adc.digital_data = '0;
        for (int i = 0; i < NUM_CH; i++) bank_model[i] = '0;
        exp_ch = 0;

        #1;
        checkOutput("rst_wr", 32'(adc.wr), 32'(1));
        checkOutput("rst_ch_sel", 32'(adc.ch_sel), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_wr", 32'(adc.wr), 32'(1));
        checkOutput("idle_busy", 32'(busy), 32'(0));
        checkOutput("idle_sample_data", 32'(sample_data), 32'(0));
        checkOutput("idle_sample_ch", 32'(sample_ch), 32'(0));
        checkOutput("idle_valid", 32'(sample_valid), 32'(0));
        checkOutput("idle_led", 32'(led_display), 32'(0));
        checkOutput("idle_err", 32'(timeout_err), 32'(0));

        $display("[TB] first conversion, ADC answers 3 cycles after wr rises");
        enable = 1'b1;
        applyStimulus(8'hA5, 3, 1'b0, 1'b0, 1'b0);

        $display("[TB] fixed-pattern scan over all channels");
        applyStimulus(8'h22, 1, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h33, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h44, 2, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h11, 4, 1'b0, 1'b1, 1'b0);
        disp_ch = 2'd2;
        @(negedge clk);
        checkOutput("led_ch2", 32'(led_display), 32'(8'h33));

        $display("[TB] randomized conversions");
        applyStimulus(DATA_W'($urandom), $urandom_range(0, 5), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(DATA_W'($urandom), $urandom_range(0, 5), 1'b0, 1'b1, 1'b0);
        end

        $display("[TB] intrupt held low before WAIT");
        applyStimulus(8'h5C, 0, 1'b1, 1'b1, 1'b0);

        $display("[TB] enable dropped during START of channel 3");
        while (exp_ch != 3) applyStimulus(DATA_W'($urandom), $urandom_range(0, 3), 1'b0, 1'b1, 1'b0);
        applyStimulus(DATA_W'($urandom), 1, 1'b0, 1'b1, 1'b1);
        wr_high_all = 1'b1;
        repeat (5) begin
            if (adc.wr !== 1'b1 || busy !== 1'b0) wr_high_all = 1'b0;
            @(negedge clk);
        end
        checkOutput("idle_after_drop", 32'(wr_high_all), 32'(1));
        enable = 1'b1;
        applyStimulus(DATA_W'($urandom), 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] reset during WAIT of channel 2");
        while (exp_ch != 2) applyStimulus(DATA_W'($urandom), $urandom_range(0, 3), 1'b0, 1'b1, 1'b0);
        disp_ch = 2'd1;
        waitWr(1'b0, n);
        waitWr(1'b1, n);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_wr", 32'(adc.wr), 32'(1));
        checkOutput("arst_ch_sel", 32'(adc.ch_sel), 32'(0));
        checkOutput("arst_led", 32'(led_display), 32'(0));
        checkOutput("arst_busy", 32'(busy), 32'(0));
        checkOutput("arst_sample_data", 32'(sample_data), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) bank_model[i] = '0;
        exp_ch = 0;
        applyStimulus(DATA_W'($urandom), 2, 1'b0, 1'b0, 1'b0);

        $display("[TB] no end-of-conversion on channel 1");
        waitWr(1'b0, n);
        waitWr(1'b1, n);
        stray_valid = 1'b0;
`ifdef ADC_SCAN_TIMEOUT_EN
        repeat (TIMEOUT_CYCLES - 1) begin
            if (sample_valid === 1'b1) stray_valid = 1'b1;
            @(negedge clk);
        end
        checkOutput("timeout_early", 32'(timeout_err), 32'(0));
        @(negedge clk);
        checkOutput("timeout_set", 32'(timeout_err), 32'(1));
        checkOutput("timeout_no_valid", 32'(stray_valid | sample_valid), 32'(0));
        checkOutput("timeout_ch_sel", 32'(adc.ch_sel), 32'(2));
        exp_ch  = 2;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checkOutput("timeout_clear", 32'(timeout_err), 32'(0));
        applyStimulus(DATA_W'($urandom), 1, 1'b0, 1'b0, 1'b0);
`else
        err_clr = 1'b1;
        repeat (40) begin
            if (sample_valid === 1'b1) stray_valid = 1'b1;
            @(negedge clk);
        end
        err_clr = 1'b0;
        checkOutput("stuck_busy", 32'(busy), 32'(1));
        checkOutput("stuck_wr", 32'(adc.wr), 32'(1));
        checkOutput("stuck_ch_sel", 32'(adc.ch_sel), 32'(1));
        checkOutput("stuck_no_valid", 32'(stray_valid), 32'(0));
        checkOutput("stuck_err", 32'(timeout_err), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
